// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Load/store controller in front of a single-port, zero-read-latency,
//   read-first data RAM. Byte-addressed requests arrive over a valid/ready
//   handshake. Sub-word stores are done as read-modify-write. Loads return
//   sign- or zero-extended data. Misaligned or reserved-size requests are
//   answered with an error response and never touch the RAM.
//
// Ports
//   clka, rsta           clock, synchronous active-high reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_we               1 = store, 0 = load
//   req_size             00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned         zero-extend loads when 1
//   req_addr             byte address (ADDR_WIDTH+2 bits, little-endian)
//   req_wdata            right-aligned store data
//   resp_valid           one-cycle completion pulse
//   resp_err             misaligned / reserved-size flag
//   resp_rdata           extended load data (0 for stores and errors)
//   ram_addra            RAM word address
//   ram_dina, ram_wea    RAM write data / write enable
//   ram_douta            RAM read data (combinational from ram_addra)
module mem_access_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic                  ram_wea,
  input  logic [DATA_WIDTH-1:0] ram_douta
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    RESP = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t                  state_q, state_d;
  logic                    we_q;
  logic [1:0]              size_q;
  logic                    uns_q;
  logic [1:0]              off_q;
  logic [ADDR_WIDTH-1:0]   waddr_q;
  // Holds the word-store data, the merged RMW word, or the extended load
  // result, depending on the operation in flight.
  logic [DATA_WIDTH-1:0]   word_q;
  logic                    accept;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      SZ_BYTE: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (size)
      SZ_BYTE: r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] size, input logic [1:0] off);
    logic [31:0] r;
    r = w;
    case (size)
      SZ_BYTE: r[{off, 3'b000} +: 8] = d[7:0];
      SZ_HALF: begin
        if (off[1]) r[31:16] = d[15:0];
        else        r[15:0]  = d[15:0];
      end
      default: r = d;
    endcase
    return r;
  endfunction

  assign accept = req_valid && (state_q == IDLE);

  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q <= IDLE;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        waddr_q <= req_addr[ADDR_WIDTH+1:2];
      end
    end
  end

  // Request attributes and the data word carry no reset; they are only
  // observed in states reached after an accept.
  always_ff @(posedge clka) begin
    if (accept) begin
      we_q   <= req_we;
      size_q <= req_size;
      uns_q  <= req_unsigned;
      off_q  <= req_addr[1:0];
      word_q <= req_wdata;
    end else if (state_q == RD) begin
      word_q <= we_q ? store_merge(ram_douta, word_q, size_q, off_q)
                     : load_extend(ram_douta, size_q, off_q, uns_q);
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    ram_dina   = '0;
    ram_wea    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (misaligned(req_size, req_addr[1:0])) state_d = ERR;
          else if (req_we && req_size == SZ_WORD)  state_d = WR;
          else                                     state_d = RD;
        end
      end
      RD: begin
        state_d = we_q ? WR : RESP;
      end
      WR: begin
        ram_wea  = ~rsta;
        ram_dina = word_q;
        state_d  = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = we_q ? '0 : word_q;
        state_d    = IDLE;
      end
      ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ram_addra = waddr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clka;
  logic        rsta;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [5:0]  ram_addra;
  logic [31:0] ram_dina;
  logic        ram_wea;
  logic [31:0] ram_douta;

  logic [31:0] mem [64];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          wea;
  } exp_t;

  exp_t sbq[$];

  mem_access_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
    .clka        (clka),
    .rsta        (rsta),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_err    (resp_err),
    .resp_rdata  (resp_rdata),
    .ram_addra   (ram_addra),
    .ram_dina    (ram_dina),
    .ram_wea     (ram_wea),
    .ram_douta   (ram_douta)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // RAM model: zero read latency, write on rising edge, read-first.
  assign ram_douta = mem[ram_addra];
  always @(posedge clka) begin
    if (ram_wea) mem[ram_addra] <= ram_dina;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [7:0] addr, input logic [31:0] wdata, input logic hold,
                        input logic eerr, input logic [31:0] erd, input int elat, input int ewea);
    exp_t e;
    int   cyc;
    int   wcnt;
    logic [5:0] waddr;
    logic seen;
    @(negedge clka);
    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    e.err = eerr; e.rdata = erd; e.lat = elat; e.wea = ewea;
    sbq.push_back(e);
    @(posedge clka);
    #1;
    if (!hold) req_valid = 1'b0;
    cyc = 0; wcnt = 0; waddr = '0; seen = 1'b0;
    while (!seen && cyc < 10) begin
      @(negedge clka);
      cyc++;
      if (ram_wea) begin
        wcnt++;
        waddr = ram_addra;
      end
      if (resp_valid) seen = 1'b1;
      else chk("busy_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    chk("resp_seen", {31'd0, seen}, 32'd1);
    e = sbq.pop_front();
    chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
    chk("resp_rdata", resp_rdata, e.rdata);
    chk("latency", cyc, e.lat);
    chk("wea_cycles", wcnt, e.wea);
    if (e.wea > 0) chk("wr_addr", {26'd0, waddr}, {26'd0, addr[7:2]});
    if (hold) begin
      @(negedge clka);
      chk("no_reaccept_vld", {31'd0, resp_valid}, 32'd0);
      chk("no_reaccept_rdy", {31'd0, req_ready}, 32'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    rsta = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 8'h00; req_wdata = 32'h0;
    repeat (2) @(posedge clka);
    @(negedge clka);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_wea", {31'd0, ram_wea}, 32'd0);
    chk("rst_addra", {26'd0, ram_addra}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    rsta = 1'b0;

    // Word store then word load
    do_req(1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 2, 1);
    chk("mem_word_store", mem[4], 32'hDEADBEEF);
    do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, 2, 0);

    // Byte store RMW, upper wdata bits must be ignored
    do_req(1'b1, 2'b00, 1'b0, 8'h11, 32'h12345680, 1'b0, 1'b0, 32'h0, 3, 1);
    chk("mem_byte_store", mem[4], 32'hDEAD80EF);
    do_req(1'b0, 2'b00, 1'b0, 8'h11, 32'h0, 1'b0, 1'b0, 32'hFFFFFF80, 2, 0);
    do_req(1'b0, 2'b00, 1'b1, 8'h11, 32'h0, 1'b0, 1'b0, 32'h00000080, 2, 0);

    // Half store RMW
    do_req(1'b1, 2'b01, 1'b0, 8'h12, 32'h5555F234, 1'b0, 1'b0, 32'h0, 3, 1);
    chk("mem_half_store", mem[4], 32'hF23480EF);
    do_req(1'b0, 2'b01, 1'b0, 8'h12, 32'h0, 1'b0, 1'b0, 32'hFFFFF234, 2, 0);
    do_req(1'b0, 2'b01, 1'b1, 8'h12, 32'h0, 1'b1, 1'b0, 32'h0000F234, 2, 0);
    do_req(1'b0, 2'b00, 1'b1, 8'h10, 32'h0, 1'b0, 1'b0, 32'h000000EF, 2, 0);

    // Error cases
    do_req(1'b0, 2'b10, 1'b0, 8'h13, 32'h0, 1'b0, 1'b1, 32'h0, 1, 0);
    do_req(1'b1, 2'b01, 1'b0, 8'h11, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0, 1, 0);
    do_req(1'b1, 2'b11, 1'b0, 8'h00, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h0, 1, 0);
    chk("mem_after_err", mem[4], 32'hF23480EF);
    chk("mem0_after_err", mem[0], 32'h0);

    // Reset during the WR cycle of a byte store
    @(negedge clka);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 8'h11; req_wdata = 32'h00000055;
    @(posedge clka);
    #1;
    req_valid = 1'b0;
    @(negedge clka);
    @(negedge clka);
    chk("pre_rst_wea", {31'd0, ram_wea}, 32'd1);
    rsta = 1'b1;
    #1;
    chk("rst_cycle_wea", {31'd0, ram_wea}, 32'd0);
    @(negedge clka);
    rsta = 1'b0;
    chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_mem", mem[4], 32'hF23480EF);
    do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 32'hF23480EF, 2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
